// File: rtl/dmem_responder.sv
// Single-port data memory responder: accepts one load/store at a time, checks
// size/alignment/range, and returns a registered one-cycle response.
module dmem_responder #(
  parameter int REG_WIDTH       = 32,
  parameter int DMEM_ADDR_WIDTH = 10,
  parameter int DMEM_DEPTH      = 1024,
  parameter int RD_LATENCY      = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [2:0]           req_funct3,
  input  logic [REG_WIDTH-1:0] req_addr,
  input  logic [REG_WIDTH-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [REG_WIDTH-1:0] rsp_rdata,
  output logic                 rsp_err
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [REG_WIDTH:0] ADDR_LIMIT = (REG_WIDTH+1)'(4 * DMEM_DEPTH);
  localparam logic [3:0]         LAT_INIT   = 4'(RD_LATENCY);

  state_t                     state, state_next;
  logic [3:0]                 lat_cnt, lat_cnt_next;
  logic                       rsp_valid_next, rsp_err_next;
  logic [REG_WIDTH-1:0]       rsp_rdata_next;

  logic                       we_q;
  logic [2:0]                 funct3_q;
  logic [DMEM_ADDR_WIDTH+1:0] addr_q;
  logic [REG_WIDTH-1:0]       wdata_q;

  logic [REG_WIDTH-1:0]       mem [DMEM_DEPTH];
  logic [DMEM_ADDR_WIDTH-1:0] word_idx;
  logic [REG_WIDTH-1:0]       cur_word, load_data, wr_mask, merged_word;
  logic [4:0]                 lane_shift;
  logic [7:0]                 byte_sel;
  logic [15:0]                half_sel;
  logic                       accept, req_err, funct3_ok, misaligned, mem_we;

  assign req_ready  = (state == IDLE) && !reset;
  assign accept     = req_valid && req_ready;
  assign word_idx   = addr_q[DMEM_ADDR_WIDTH+1:2];
  assign cur_word   = mem[word_idx];
  assign lane_shift = {addr_q[1:0], 3'b000};
  assign byte_sel   = cur_word[lane_shift +: 8];
  assign half_sel   = cur_word[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    funct3_ok  = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                        : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = (req_addr[1:0] != 2'b00);
      default: misaligned = 1'b0;
    endcase
    req_err = !funct3_ok || misaligned || ({1'b0, req_addr} >= ADDR_LIMIT);
  end

  always_comb begin
    case (funct3_q)
      3'b000:  load_data = {{(REG_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b001:  load_data = {{(REG_WIDTH-16){half_sel[15]}}, half_sel};
      3'b100:  load_data = {{(REG_WIDTH-8){1'b0}}, byte_sel};
      3'b101:  load_data = {{(REG_WIDTH-16){1'b0}}, half_sel};
      default: load_data = cur_word;
    endcase
  end

  // Read-modify-write merge so untouched byte lanes keep their old value
  always_comb begin
    case (funct3_q[1:0])
      2'b00:   wr_mask = REG_WIDTH'(8'hFF) << lane_shift;
      2'b01:   wr_mask = REG_WIDTH'(16'hFFFF) << lane_shift;
      default: wr_mask = '1;
    endcase
    merged_word = (cur_word & ~wr_mask) | ((wdata_q << lane_shift) & wr_mask);
  end

  always_comb begin
    state_next     = state;
    lat_cnt_next   = lat_cnt;
    rsp_valid_next = 1'b0;
    rsp_err_next   = 1'b0;
    rsp_rdata_next = '0;
    mem_we         = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err) begin
            state_next     = RESP;
            rsp_valid_next = 1'b1;
            rsp_err_next   = 1'b1;
          end else if (req_we) begin
            state_next = WRITE;
          end else begin
            state_next   = READ;
            lat_cnt_next = LAT_INIT;
          end
        end
      end
      READ: begin
        if (lat_cnt <= 4'd1) begin
          state_next     = RESP;
          lat_cnt_next   = 4'd0;
          rsp_valid_next = 1'b1;
          rsp_rdata_next = load_data;
        end else begin
          lat_cnt_next = lat_cnt - 4'd1;
        end
      end
      WRITE: begin
        mem_we         = 1'b1;
        state_next     = RESP;
        rsp_valid_next = 1'b1;
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      lat_cnt   <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state     <= state_next;
      lat_cnt   <= lat_cnt_next;
      rsp_valid <= rsp_valid_next;
      rsp_err   <= rsp_err_next;
      rsp_rdata <= rsp_rdata_next;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q     <= req_we;
      funct3_q <= req_funct3;
      addr_q   <= req_addr[DMEM_ADDR_WIDTH+1:0];
      wdata_q  <= req_wdata;
    end
  end

  // Memory is never cleared; a reset edge during WRITE suppresses the commit
  always_ff @(posedge clk) begin
    if (!reset && mem_we && we_q) begin
      mem[word_idx] <= merged_word;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus random traffic
// compared against a byte-addressed behavioural memory model.
module tb_dmem_responder;

  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1024;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_mem [0:4*DEPTH-1];

  dmem_responder #(
    .REG_WIDTH(32), .DMEM_ADDR_WIDTH(10), .DMEM_DEPTH(DEPTH), .RD_LATENCY(RD_LAT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Applies one request to the byte-array model; returns the response the DUT should give
  function automatic void model_req(input bit we, input logic [2:0] f3,
                                    input logic [31:0] addr, input logic [31:0] wd,
                                    output logic [31:0] rd, output bit er, output int lat);
    int unsigned size;
    bit legal;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    er    = !legal || (addr % size != 0) || (addr >= 4 * DEPTH);
    rd    = 32'd0;
    if (er) begin
      lat = 1;
    end else if (we) begin
      for (int i = 0; i < int'(size); i++) model_mem[addr + i] = wd[8*i +: 8];
      lat = 2;
    end else begin
      v = 32'd0;
      for (int i = 0; i < int'(size); i++) v = v | ({24'd0, model_mem[addr + i]} << (8 * i));
      if (!f3[2] && size == 1 && v[7])  v = v | 32'hFFFF_FF00;
      if (!f3[2] && size == 2 && v[15]) v = v | 32'hFFFF_0000;
      rd  = v;
      lat = RD_LAT + 1;
    end
  endfunction

  task automatic applyStimulus(input string tag, input bit we, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               output logic [31:0] obs_rd);
    logic [31:0] exp_rd;
    bit exp_err;
    int exp_lat, cycles, ready_viol, idle_dirty;
    @(negedge clk);
    checkOutput({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    model_req(we, f3, addr, wd, exp_rd, exp_err, exp_lat);
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    cycles     = 1;
    ready_viol = 0;
    idle_dirty = 0;
    while (rsp_valid !== 1'b1 && cycles < 40) begin
      if (req_ready) ready_viol++;
      if (rsp_rdata !== 32'd0 || rsp_err !== 1'b0) idle_dirty++;
      @(negedge clk);
      cycles++;
    end
    if (req_ready) ready_viol++;
    obs_rd = rsp_rdata;
    checkOutput({tag, ".rdata"}, rsp_rdata, exp_rd);
    checkOutput({tag, ".err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    checkOutput({tag, ".latency"}, cycles, exp_lat);
    checkOutput({tag, ".busy_ready"}, ready_viol, 0);
    checkOutput({tag, ".idle_zero"}, idle_dirty, 0);
  endtask

  logic [31:0] rd;
  logic [31:0] q_we, q_f3, q_addr, q_wd;
  logic [31:0] exp_rd_q [4];
  bit          exp_err_q [4];
  int          exp_lat_q [4];
  int          acc_cyc_q [4];
  logic [31:0] e_rd;
  bit          e_err, busy, saw;
  int          e_lat, nacc, nresp, viol, extra, cyc, drive_idx;
  bit          rdy;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    checkOutput("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    checkOutput("rst.rsp_rdata", rsp_rdata, 32'd0);
    checkOutput("rst.rsp_err", {31'd0, rsp_err}, 32'd0);
    checkOutput("rst.ready_low", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1 checkOutput("rst.ready_after", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 16; i++) applyStimulus("init", 1'b1, 3'b010, 32'(i * 4), $urandom, rd);
    applyStimulus("init200", 1'b1, 3'b010, 32'h200, 32'hCAFE_F00D, rd);

    applyStimulus("sw100", 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, rd);
    checkOutput("sw100.zero", rd, 32'd0);
    applyStimulus("lw100", 1'b0, 3'b010, 32'h100, 32'd0, rd);
    checkOutput("lw100.const", rd, 32'hDEAD_BEEF);
    applyStimulus("sb101", 1'b1, 3'b000, 32'h101, 32'h55, rd);
    applyStimulus("lw100b", 1'b0, 3'b010, 32'h100, 32'd0, rd);
    checkOutput("lw100b.const", rd, 32'hDEAD_55EF);
    applyStimulus("lb103", 1'b0, 3'b000, 32'h103, 32'd0, rd);
    checkOutput("lb103.const", rd, 32'hFFFF_FFDE);
    applyStimulus("lbu103", 1'b0, 3'b100, 32'h103, 32'd0, rd);
    checkOutput("lbu103.const", rd, 32'h0000_00DE);
    applyStimulus("lhu102", 1'b0, 3'b101, 32'h102, 32'd0, rd);
    checkOutput("lhu102.const", rd, 32'h0000_DEAD);

    applyStimulus("lw_mis", 1'b0, 3'b010, 32'h102, 32'd0, rd);
    applyStimulus("sh_mis", 1'b1, 3'b001, 32'h001, 32'hFFFF, rd);
    applyStimulus("lw_oor", 1'b0, 3'b010, 32'h1000, 32'd0, rd);
    applyStimulus("ld_badf3", 1'b0, 3'b011, 32'h100, 32'd0, rd);
    applyStimulus("st_badf3", 1'b1, 3'b100, 32'h000, 32'hFFFF_FFFF, rd);
    applyStimulus("lw0_after", 1'b0, 3'b010, 32'h000, 32'd0, rd);
    applyStimulus("lw100_after", 1'b0, 3'b010, 32'h100, 32'd0, rd);
    checkOutput("lw100_after.const", rd, 32'hDEAD_55EF);

    // Load aborted by reset during its first READ cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h100;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_ld.ready_in_reset", {31'd0, req_ready}, 32'd0);
    checkOutput("abort_ld.valid_in_reset", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    #1 checkOutput("abort_ld.ready_after", {31'd0, req_ready}, 32'd1);
    saw = 1'b0;
    repeat (8) begin @(negedge clk); saw = saw | rsp_valid; end
    checkOutput("abort_ld.no_rsp", {31'd0, saw}, 32'd0);
    applyStimulus("abort_ld.lw100", 1'b0, 3'b010, 32'h100, 32'd0, rd);
    checkOutput("abort_ld.retained", rd, 32'hDEAD_55EF);

    // Store aborted by reset during its WRITE cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h200; req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("abort_st.valid_in_reset", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b0;
    saw = 1'b0;
    repeat (4) begin @(negedge clk); saw = saw | rsp_valid; end
    checkOutput("abort_st.no_rsp", {31'd0, saw}, 32'd0);
    applyStimulus("abort_st.lw200", 1'b0, 3'b010, 32'h200, 32'd0, rd);
    checkOutput("abort_st.prior", rd, 32'hCAFE_F00D);

    // Four requests with req_valid held high throughout
    q_we   = {8'd0, 8'd1, 8'd0, 8'd1};
    q_f3   = {8'd0, 8'd1, 8'd2, 8'd2};
    q_addr = {8'h21, 8'h22, 8'h20, 8'h20};
    q_wd   = 32'h0BAD_F07F;
    drive_idx = 0; nacc = 0; nresp = 0; viol = 0; extra = 0; cyc = 0; busy = 1'b0;
    req_valid  = 1'b1;
    req_we     = q_we[0];
    req_funct3 = q_f3[2:0];
    req_addr   = {24'd0, q_addr[7:0]};
    req_wdata  = 32'h0BAD_F00D;
    while (nresp < 4 && cyc < 80) begin
      rdy = req_ready;
      @(posedge clk);
      if (rdy && req_valid && nacc < 4) begin
        model_req(req_we, req_funct3, req_addr, req_wdata,
                  exp_rd_q[nacc], exp_err_q[nacc], exp_lat_q[nacc]);
        acc_cyc_q[nacc] = cyc;
        nacc++;
        busy = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (busy && req_ready) viol++;
      if (rsp_valid) begin
        if (nresp < nacc) begin
          checkOutput("queued.rdata", rsp_rdata, exp_rd_q[nresp]);
          checkOutput("queued.err", {31'd0, rsp_err}, {31'd0, exp_err_q[nresp]});
          checkOutput("queued.latency", cyc - acc_cyc_q[nresp], exp_lat_q[nresp]);
          nresp++;
        end else begin
          extra++;
        end
        busy = 1'b0;
      end
      if (rdy && drive_idx == nacc - 1) begin
        drive_idx++;
        if (drive_idx < 4) begin
          req_we     = q_we[8*drive_idx];
          req_funct3 = q_f3[8*drive_idx +: 3];
          req_addr   = {24'd0, q_addr[8*drive_idx +: 8]};
          req_wdata  = q_wd;
        end
      end
    end
    req_valid = 1'b0;
    repeat (5) begin @(negedge clk); if (rsp_valid) extra++; end
    checkOutput("queued.accepts", nacc, 4);
    checkOutput("queued.responses", nresp, 4);
    checkOutput("queued.busy_ready", viol, 0);
    checkOutput("queued.extra_rsp", extra, 0);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      if ($urandom_range(0, 9) == 0) a = 32'h1000 + 32'($urandom_range(0, 63));
      else a = 32'($urandom_range(0, 63));
      applyStimulus("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
